// File: rtl/addr_gen_mem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// addr_gen_mem_arbiter_pkg : shared widths and response-stage type
// Rev 1.0
// ----------------------------------------------------------------------------
package addr_gen_mem_arbiter_pkg;

  localparam int NUM_CH_MAX = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Stage id is sized for the widest supported channel count so one type fits every build
  localparam int STAGE_ID_W = id_width(NUM_CH_MAX);

  typedef struct packed {
    logic                  valid;
    logic [STAGE_ID_W-1:0] id;
  } resp_stage_t;

endpackage
`default_nettype wire

// File: rtl/addr_gen_mem_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// addr_gen_mem_arbiter_if : channel request/response and memory port bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface addr_gen_mem_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH-1:0]        ch_rvalid;
  logic [DATA_W-1:0]        rdata;
  logic                     mem_en;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_rdata;

  modport master (
    output ch_valid, ch_addr, mem_rdata,
    input  ch_ready, ch_rvalid, rdata, mem_en, mem_addr
  );

  modport slave (
    input  ch_valid, ch_addr, mem_rdata,
    output ch_ready, ch_rvalid, rdata, mem_en, mem_addr
  );
endinterface
`default_nettype wire

// File: rtl/addr_gen_mem_arbiter_rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// addr_gen_mem_arbiter_rr_pick : first set request scanning upward from a base
// Rev 1.0
// ----------------------------------------------------------------------------
module addr_gen_mem_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  wire logic [N-1:0]     i_req,
  input  wire logic [IDX_W-1:0] i_base,
  output logic                  o_found,
  output logic [IDX_W-1:0]      o_idx
);

  logic [IDX_W-1:0] w_j;

  // Scan from the far end so the candidate nearest the base is written last
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IDX_W'((int'(i_base) + k) % N);
      if (i_req[w_j]) begin
        o_found = 1'b1;
        o_idx   = w_j;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/addr_gen_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// addr_gen_mem_arbiter : round-robin, burst-locked sharing of one read port
// Rev 1.0
// ----------------------------------------------------------------------------
module addr_gen_mem_arbiter
  import addr_gen_mem_arbiter_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1,
  parameter int MAX_BURST = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  addr_gen_mem_arbiter_if.slave bus
);

  localparam int ID_W = id_width(NUM_CH);
  localparam int BC_W = $clog2(MAX_BURST + 1);

  logic [ID_W-1:0]   r_ptr, r_owner;
  logic              r_locked;
  logic [BC_W-1:0]   r_burst_cnt;
  logic [ID_W-1:0]   w_ptr_nxt, w_owner_nxt;
  logic              w_locked_nxt;
  logic [BC_W-1:0]   w_burst_cnt_nxt;

  logic              w_hold, w_found, w_grant_vld;
  logic [ID_W-1:0]   w_scan_idx, w_grant_id;
  logic [ADDR_W-1:0] w_ch_addr [NUM_CH];

  resp_stage_t       r_pipe [MEM_LAT];
  logic [NUM_CH-1:0] r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_addr
    assign w_ch_addr[i] = bus.ch_addr[i*ADDR_W +: ADDR_W];
  end

  addr_gen_mem_arbiter_rr_pick #(
    .N     (NUM_CH),
    .IDX_W (ID_W)
  ) u_pick (
    .i_req   (bus.ch_valid),
    .i_base  (r_ptr),
    .o_found (w_found),
    .o_idx   (w_scan_idx)
  );

  assign w_hold      = r_locked & bus.ch_valid[r_owner];
  assign w_grant_vld = ~rst & (w_hold | w_found);
  assign w_grant_id  = w_hold ? r_owner : w_scan_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_locked    <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_locked    <= w_locked_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  always_comb begin
    w_ptr_nxt       = r_ptr;
    w_owner_nxt     = r_owner;
    w_locked_nxt    = r_locked;
    w_burst_cnt_nxt = r_burst_cnt;
    // An owner that stops requesting gives up the lock in the same cycle
    if (r_locked && !bus.ch_valid[r_owner]) begin
      w_locked_nxt    = 1'b0;
      w_burst_cnt_nxt = '0;
    end
    if (w_grant_vld) begin
      w_ptr_nxt = (w_grant_id == ID_W'(NUM_CH - 1)) ? '0 : w_grant_id + 1'b1;
      if (w_hold) begin
        if ((r_burst_cnt + BC_W'(1)) == BC_W'(MAX_BURST)) begin
          w_locked_nxt    = 1'b0;
          w_burst_cnt_nxt = '0;
        end else begin
          w_burst_cnt_nxt = r_burst_cnt + BC_W'(1);
        end
      end else begin
        w_owner_nxt     = w_grant_id;
        w_burst_cnt_nxt = BC_W'(1);
        w_locked_nxt    = (MAX_BURST > 1);
      end
    end
  end

  always_comb begin
    bus.ch_ready = '0;
    bus.mem_en   = 1'b0;
    bus.mem_addr = '0;
    if (w_grant_vld) begin
      bus.ch_ready = NUM_CH'(1) << w_grant_id;
      bus.mem_en   = 1'b1;
      bus.mem_addr = w_ch_addr[w_grant_id];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < MEM_LAT; s++) r_pipe[s] <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_pipe[0].valid <= w_grant_vld;
      r_pipe[0].id    <= STAGE_ID_W'(w_grant_id);
      for (int s = 1; s < MEM_LAT; s++) r_pipe[s] <= r_pipe[s-1];
      r_rvalid <= '0;
      if (r_pipe[MEM_LAT-1].valid) begin
        r_rvalid <= NUM_CH'(1) << r_pipe[MEM_LAT-1].id;
        r_rdata  <= bus.mem_rdata;
      end
    end
  end

  assign bus.ch_rvalid = r_rvalid;
  assign bus.rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_addr_gen_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_addr_gen_mem_arbiter : three configurations driven in parallel against a reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_addr_gen_mem_arbiter;
  localparam int N    = 4;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int NCFG = 3;
  localparam int SLOTS = 1024;
  localparam logic [DW-1:0] JUNK = 32'hDEAD_BEEF;

  int mb_of [NCFG] = '{4, 1, 2};
  int ml_of [NCFG] = '{1, 3, 2};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    valid;
  logic [N*AW-1:0] addrs;

  addr_gen_mem_arbiter_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) bus0 ();
  addr_gen_mem_arbiter_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
  addr_gen_mem_arbiter_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) bus2 ();

  addr_gen_mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_BURST(4))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  addr_gen_mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .MAX_BURST(1))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  addr_gen_mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .MAX_BURST(2))
    u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.ch_valid = valid;  assign bus0.ch_addr = addrs;
  assign bus1.ch_valid = valid;  assign bus1.ch_addr = addrs;
  assign bus2.ch_valid = valid;  assign bus2.ch_addr = addrs;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return 32'h9E37_79B9 * {22'b0, a} + 32'h0000_1234;
  endfunction

  // Memory: word for an address appears exactly MEM_LAT cycles after mem_en, junk otherwise
  logic          h_en   [NCFG][4];
  logic [AW-1:0] h_addr [NCFG][4];
  always @(posedge clk) begin
    for (int c = 0; c < NCFG; c++)
      for (int k = 3; k > 0; k--) begin
        h_en[c][k]   <= h_en[c][k-1];
        h_addr[c][k] <= h_addr[c][k-1];
      end
    h_en[0][0] <= bus0.mem_en;  h_addr[0][0] <= bus0.mem_addr;
    h_en[1][0] <= bus1.mem_en;  h_addr[1][0] <= bus1.mem_addr;
    h_en[2][0] <= bus2.mem_en;  h_addr[2][0] <= bus2.mem_addr;
  end
  assign bus0.mem_rdata = (h_en[0][0] === 1'b1) ? memf(h_addr[0][0]) : JUNK;
  assign bus1.mem_rdata = (h_en[1][2] === 1'b1) ? memf(h_addr[1][2]) : JUNK;
  assign bus2.mem_rdata = (h_en[2][1] === 1'b1) ? memf(h_addr[2][1]) : JUNK;

  logic [N-1:0]  o_ready [NCFG];
  logic [N-1:0]  o_rvld  [NCFG];
  logic          o_en    [NCFG];
  logic [AW-1:0] o_addr  [NCFG];
  logic [DW-1:0] o_rdata [NCFG];
  assign o_ready[0] = bus0.ch_ready; assign o_rvld[0] = bus0.ch_rvalid; assign o_en[0] = bus0.mem_en;
  assign o_addr[0]  = bus0.mem_addr; assign o_rdata[0] = bus0.rdata;
  assign o_ready[1] = bus1.ch_ready; assign o_rvld[1] = bus1.ch_rvalid; assign o_en[1] = bus1.mem_en;
  assign o_addr[1]  = bus1.mem_addr; assign o_rdata[1] = bus1.rdata;
  assign o_ready[2] = bus2.ch_ready; assign o_rvld[2] = bus2.ch_rvalid; assign o_en[2] = bus2.mem_en;
  assign o_addr[2]  = bus2.mem_addr; assign o_rdata[2] = bus2.rdata;

  // Reference model: where the rotation resumes, who holds the port and how many beats it used
  int            m_base  [NCFG];
  int            m_owner [NCFG];
  int            m_beats [NCFG];
  logic [DW-1:0] m_last  [NCFG];
  int            exp_ch  [NCFG][SLOTS];
  logic [DW-1:0] exp_dat [NCFG][SLOTS];
  int            obs_g   [NCFG];

  int cyc;
  int n_chk;
  int n_fail;

  task automatic chk(input string tag, input int c, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cfg%0d cyc%0d observed=%0h expected=%0h", tag, c, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCFG; c++) begin
      m_base[c] = 0; m_owner[c] = 0; m_beats[c] = 0; m_last[c] = '0;
      for (int s = 0; s < SLOTS; s++) exp_ch[c][s] = -1;
    end
  endtask

  function automatic int model_grant(input int c);
    if (m_beats[c] > 0 && valid[m_owner[c]]) return m_owner[c];
    for (int k = 0; k < N; k++)
      if (valid[(m_base[c] + k) % N]) return (m_base[c] + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic step();
    int g, slot, due;
    logic [63:0] one;
    #1;
    for (int c = 0; c < NCFG; c++) begin
      g   = rst ? -1 : model_grant(c);
      one = 64'd1;
      chk("ch_ready", c, 64'(o_ready[c]), (g < 0) ? 64'd0 : (one << g));
      chk("mem_en", c, 64'(o_en[c]), 64'(g >= 0));
      chk("mem_addr", c, 64'(o_addr[c]), (g < 0) ? 64'd0 : 64'(addrs[g*AW +: AW]));
      slot = cyc % SLOTS;
      if (exp_ch[c][slot] >= 0) begin
        chk("ch_rvalid", c, 64'(o_rvld[c]), one << exp_ch[c][slot]);
        chk("rdata", c, 64'(o_rdata[c]), 64'(exp_dat[c][slot]));
        m_last[c] = exp_dat[c][slot];
      end else begin
        chk("ch_rvalid_idle", c, 64'(o_rvld[c]), 64'd0);
        chk("rdata_hold", c, 64'(o_rdata[c]), 64'(m_last[c]));
      end
      exp_ch[c][slot] = -1;
      obs_g[c] = onehot_idx(o_ready[c]);
      if (g >= 0) begin
        due = (cyc + ml_of[c] + 1) % SLOTS;
        exp_ch[c][due]  = g;
        exp_dat[c][due] = memf(addrs[g*AW +: AW]);
        if (m_beats[c] > 0 && g == m_owner[c]) begin
          m_beats[c]++;
          if (m_beats[c] == mb_of[c]) m_beats[c] = 0;
        end else begin
          m_owner[c] = g;
          m_beats[c] = (mb_of[c] > 1) ? 1 : 0;
        end
        m_base[c] = (g + 1) % N;
      end else begin
        m_beats[c] = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_addrs();
    for (int i = 0; i < N; i++) addrs[i*AW +: AW] = AW'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    valid = '0; addrs = '0; rst = 1'b1;
    model_reset();
    step();
    valid = '1;
    step();
    rst = 1'b0;
    valid = '0;
    step();

    // Single streaming channel at ascending word addresses
    for (int k = 0; k < 6; k++) begin
      valid = 4'b0100;
      rand_addrs();
      addrs[2*AW +: AW] = AW'(16 + 4 * k);
      step();
      chk("stream_grant", 0, 64'(obs_g[0]), 64'd2);
    end
    valid = '0;
    repeat (6) step();

    // Everyone requesting from reset: burst length decides the rotation pattern
    do_reset();
    valid = '1;
    for (int k = 0; k < 20; k++) begin
      rand_addrs();
      step();
      chk("burst4_seq", 0, 64'(obs_g[0]), 64'((k / 4) % 4));
      chk("rr_seq", 1, 64'(obs_g[1]), 64'(k % 4));
      chk("burst2_seq", 2, 64'(obs_g[2]), 64'((k / 2) % 4));
    end
    valid = '0;
    repeat (6) step();

    // Locked ch1 drops out; ch3 is next after it even though ch0 is also waiting
    do_reset();
    valid = 4'b0010;
    rand_addrs(); step();
    rand_addrs(); step();
    valid = 4'b1001;
    rand_addrs(); step();
    for (int c = 0; c < NCFG; c++) chk("lock_drop", c, 64'(obs_g[c]), 64'd3);
    rand_addrs(); step();
    valid = '0;
    repeat (6) step();

    // Interleaved channels through the deep pipeline
    do_reset();
    valid = 4'b0001; rand_addrs(); step();
    valid = 4'b0010; rand_addrs(); step();
    valid = 4'b0001; rand_addrs(); step();
    valid = '0;
    repeat (6) step();

    // Reset with a read in flight: nothing may surface afterwards
    valid = 4'b0100; rand_addrs(); step();
    valid = '1;
    do_reset();
    valid = 4'b0110; rand_addrs(); step();
    for (int c = 0; c < NCFG; c++) chk("post_reset_grant", c, 64'(obs_g[c]), 64'd1);
    valid = '0;
    repeat (6) step();

    // Random traffic with persistent request masks to form bursts
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) valid = N'($urandom);
      rand_addrs();
      if (k == 200) begin
        valid = '1;
        do_reset();
      end
      step();
    end
    valid = '0;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
